// File: rtl/alu_writeback_stage_pkg.sv
// Shared definitions for the ALU writeback stage: condition codes, NZCV bit positions and FSM states.
// Decode reuses the same condition-code set.
package alu_writeback_stage_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WR_SINGLE  = 2'd1,
        ST_WR_LO_LONG = 2'd2,
        ST_WR_HI      = 2'd3
    } wb_state_e;

endpackage

// File: rtl/alu_writeback_stage_cond_check.sv
// Combinational ARMv4 condition-code evaluator: cond field plus {N,Z,C,V} gives pass/fail.
module alu_writeback_stage_cond_check
    import alu_writeback_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = nzcv[NZCV_N];
    assign z_flag = nzcv[NZCV_Z];
    assign c_flag = nzcv[NZCV_C];
    assign v_flag = nzcv[NZCV_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_flag;
            COND_NE: pass = !z_flag;
            COND_CS: pass = c_flag;
            COND_CC: pass = !c_flag;
            COND_MI: pass = n_flag;
            COND_PL: pass = !n_flag;
            COND_VS: pass = v_flag;
            COND_VC: pass = !v_flag;
            COND_HI: pass = c_flag && !z_flag;
            COND_LS: pass = !c_flag || z_flag;
            COND_GE: pass = (n_flag == v_flag);
            COND_LT: pass = (n_flag != v_flag);
            COND_GT: pass = !z_flag && (n_flag == v_flag);
            COND_LE: pass = z_flag || (n_flag != v_flag);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage after the ALU: condition check, flag update, register-file write (64b results
// retire as lo then hi), and saturating retired/squashed counters.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_cond,
    input  logic                in_set_flg,
    input  logic                in_wr_en,
    input  logic                in_long,
    input  logic [REG_AW-1:0]   in_rd_lo,
    input  logic [REG_AW-1:0]   in_rd_hi,
    input  logic [2*DATA_W-1:0] alu_out,
    input  logic [3:0]          alu_nzcv,
    output logic                wb_en,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [DATA_W-1:0]   wb_data,
    output logic [3:0]          flags_q,
    output logic [CNT_W-1:0]    retired,
    output logic [CNT_W-1:0]    squashed
);

    wb_state_e           state_q,    state_d;
    logic [REG_AW-1:0]   wb_addr_q,  wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q,  wb_data_d;
    logic [DATA_W-1:0]   hi_data_q,  hi_data_d;
    logic [REG_AW-1:0]   rd_hi_q,    rd_hi_d;
    logic [3:0]          flags_reg_q, flags_reg_d;
    logic [CNT_W-1:0]    retired_q,  retired_d;
    logic [CNT_W-1:0]    squashed_q, squashed_d;

    logic accept;
    logic cond_pass;

    alu_writeback_stage_cond_check u_cond_check (
        .cond (in_cond),
        .nzcv (flags_reg_q),
        .pass (cond_pass)
    );

    assign in_ready = (state_q != ST_WR_LO_LONG);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = ST_IDLE;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        hi_data_d   = hi_data_q;
        rd_hi_d     = rd_hi_q;
        flags_reg_d = flags_reg_q;
        retired_d   = retired_q;
        squashed_d  = squashed_q;

        if (state_q == ST_WR_LO_LONG) begin
            // Second beat of a long result: nothing can be accepted this cycle.
            state_d   = ST_WR_HI;
            wb_addr_d = rd_hi_q;
            wb_data_d = hi_data_q;
        end else if (accept) begin
            if (cond_pass) begin
                if (retired_q != {CNT_W{1'b1}}) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                if (in_set_flg) begin
                    flags_reg_d = alu_nzcv;
                end
                if (in_wr_en) begin
                    state_d   = in_long ? ST_WR_LO_LONG : ST_WR_SINGLE;
                    wb_addr_d = in_rd_lo;
                    wb_data_d = alu_out[DATA_W-1:0];
                    if (in_long) begin
                        hi_data_d = alu_out[2*DATA_W-1:DATA_W];
                        rd_hi_d   = in_rd_hi;
                    end
                end
            end else if (squashed_q != {CNT_W{1'b1}}) begin
                squashed_d = squashed_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            hi_data_q   <= '0;
            rd_hi_q     <= '0;
            flags_reg_q <= 4'b0000;
            retired_q   <= '0;
            squashed_q  <= '0;
        end else begin
            state_q     <= state_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            hi_data_q   <= hi_data_d;
            rd_hi_q     <= rd_hi_d;
            flags_reg_q <= flags_reg_d;
            retired_q   <= retired_d;
            squashed_q  <= squashed_d;
        end
    end

    assign wb_en    = (state_q != ST_IDLE);
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign flags_q  = flags_reg_q;
    assign retired  = retired_q;
    assign squashed = squashed_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed vector table, reset/saturation sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_alu_writeback_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [3:0]          in_cond = 4'hE;
    logic                in_set_flg = 1'b0;
    logic                in_wr_en = 1'b0;
    logic                in_long = 1'b0;
    logic [REG_AW-1:0]   in_rd_lo = '0;
    logic [REG_AW-1:0]   in_rd_hi = '0;
    logic [2*DATA_W-1:0] alu_out = '0;
    logic [3:0]          alu_nzcv = '0;
    logic                wb_en;
    logic [REG_AW-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic [3:0]          flags_q;
    logic [CNT_W-1:0]    retired;
    logic [CNT_W-1:0]    squashed;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cond    (in_cond),
        .in_set_flg (in_set_flg),
        .in_wr_en   (in_wr_en),
        .in_long    (in_long),
        .in_rd_lo   (in_rd_lo),
        .in_rd_hi   (in_rd_hi),
        .alu_out    (alu_out),
        .alu_nzcv   (alu_nzcv),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flags_q    (flags_q),
        .retired    (retired),
        .squashed   (squashed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic s, input logic w,
                         input logic l, input logic [3:0] rlo, input logic [3:0] rhi,
                         input logic [63:0] a, input logic [3:0] nz);
        in_valid = v; in_cond = c; in_set_flg = s; in_wr_en = w; in_long = l;
        in_rd_lo = rlo; in_rd_hi = rhi; alu_out = a; alu_nzcv = nz;
    endtask

    // Reference condition evaluation: even codes test a base predicate, odd codes its inverse.
    function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    typedef struct {
        logic        v;
        logic [3:0]  cond;
        logic        s, wr, lng;
        logic [3:0]  rlo, rhi;
        logic [63:0] alu;
        logic [3:0]  nz;
        logic        e_en;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_flg;
        logic        e_rdy;
        logic [15:0] e_ret, e_sq;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[14];

    initial begin
        wr_t         pend[$];
        wr_t         e;
        bit          m_en, m_rdy, acc, p;
        logic [3:0]  m_addr, m_flags;
        logic [31:0] m_data;
        int          m_ret, m_sq;

        // inputs applied in a cycle -> outputs expected in the following cycle
        vecs[0]  = '{1, 4'hE, 1, 1, 0, 4'd3, 4'd0, 64'h5, 4'b0100, 1, 4'd3, 32'h5, 4'b0100, 1, 16'd1, 16'd0};
        vecs[1]  = '{1, 4'h0, 0, 1, 0, 4'd4, 4'd0, 64'h7, 4'b0000, 1, 4'd4, 32'h7, 4'b0100, 1, 16'd2, 16'd0};
        vecs[2]  = '{1, 4'h1, 0, 1, 0, 4'd5, 4'd0, 64'h9, 4'b0000, 0, 4'd4, 32'h7, 4'b0100, 1, 16'd2, 16'd1};
        vecs[3]  = '{1, 4'hE, 0, 1, 1, 4'd1, 4'd2, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0000, 1, 4'd1, 32'hCCCC_DDDD, 4'b0100, 0, 16'd3, 16'd1};
        vecs[4]  = '{1, 4'hE, 0, 1, 1, 4'd1, 4'd2, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0000, 1, 4'd2, 32'hAAAA_BBBB, 4'b0100, 1, 16'd3, 16'd1};
        vecs[5]  = '{1, 4'hE, 0, 1, 0, 4'd7, 4'd0, 64'h11, 4'b0000, 1, 4'd7, 32'h11, 4'b0100, 1, 16'd4, 16'd1};
        vecs[6]  = '{1, 4'hE, 1, 0, 0, 4'd0, 4'd0, 64'h0, 4'b0010, 0, 4'd7, 32'h11, 4'b0010, 1, 16'd5, 16'd1};
        vecs[7]  = '{1, 4'h2, 0, 1, 0, 4'd6, 4'd0, 64'h66, 4'b0000, 1, 4'd6, 32'h66, 4'b0010, 1, 16'd6, 16'd1};
        vecs[8]  = '{1, 4'hF, 1, 1, 0, 4'd8, 4'd0, 64'h88, 4'b1111, 0, 4'd6, 32'h66, 4'b0010, 1, 16'd6, 16'd2};
        vecs[9]  = '{1, 4'hE, 0, 0, 1, 4'd10, 4'd11, 64'hFFFF_0000_FFFF_0000, 4'b0000, 0, 4'd6, 32'h66, 4'b0010, 1, 16'd7, 16'd2};
        vecs[10] = '{1, 4'hE, 0, 1, 1, 4'd9, 4'd9, 64'h1234_5678_9ABC_DEF0, 4'b0000, 1, 4'd9, 32'h9ABC_DEF0, 4'b0010, 0, 16'd8, 16'd2};
        vecs[11] = '{0, 4'hE, 0, 1, 0, 4'd1, 4'd1, 64'h0, 4'b0000, 1, 4'd9, 32'h1234_5678, 4'b0010, 1, 16'd8, 16'd2};
        vecs[12] = '{0, 4'hE, 0, 1, 0, 4'd1, 4'd1, 64'h0, 4'b0000, 0, 4'd9, 32'h1234_5678, 4'b0010, 1, 16'd8, 16'd2};
        vecs[13] = '{1, 4'h0, 0, 1, 1, 4'd12, 4'd13, 64'h1, 4'b0000, 0, 4'd9, 32'h1234_5678, 4'b0010, 1, 16'd8, 16'd3};

        // ---- reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_wb_en", wb_en, 0);
        check("rst_addr", wb_addr, 0);
        check("rst_data", wb_data, 0);
        check("rst_flags", flags_q, 0);
        check("rst_retired", retired, 0);
        check("rst_squashed", squashed, 0);
        check("rst_ready", in_ready, 1);

        // ---- reset held two cycles in the middle of a long write
        drive(1, 4'hE, 1, 1, 1, 4'd1, 4'd2, 64'h1111_2222_3333_4444, 4'b1111);
        step();
        check("mid_long_wb_en", wb_en, 1);
        check("mid_long_flags", flags_q, 4'b1111);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst2_wb_en", wb_en, 0);
        check("rst2_flags", flags_q, 0);
        check("rst2_retired", retired, 0);
        check("rst2_squashed", squashed, 0);
        check("rst2_ready", in_ready, 1);
        step();
        check("rst2_no_hi_write", wb_en, 0);

        // ---- directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].cond, vecs[i].s, vecs[i].wr, vecs[i].lng,
                  vecs[i].rlo, vecs[i].rhi, vecs[i].alu, vecs[i].nz);
            step();
            check($sformatf("vec%0d_wb_en", i), wb_en, vecs[i].e_en);
            check($sformatf("vec%0d_addr", i), wb_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_data", i), wb_data, vecs[i].e_data);
            check($sformatf("vec%0d_flags", i), flags_q, vecs[i].e_flg);
            check($sformatf("vec%0d_ready", i), in_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_retired", i), retired, vecs[i].e_ret);
            check($sformatf("vec%0d_squashed", i), squashed, vecs[i].e_sq);
        end

        // ---- randomized traffic against the reference model
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_en = 0; m_addr = 0; m_data = 0; m_flags = 0; m_ret = 0; m_sq = 0;
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  4'($urandom), 4'($urandom), {$urandom, $urandom}, 4'($urandom));
            m_rdy = (pend.size() == 0);
            check("rnd_ready", in_ready, m_rdy);
            acc = in_valid && m_rdy;
            if (acc) begin
                p = model_pass(in_cond, m_flags);
                if (p) begin
                    m_ret++;
                    if (in_set_flg) m_flags = alu_nzcv;
                    if (in_wr_en) begin
                        pend.push_back('{in_rd_lo, alu_out[31:0]});
                        if (in_long) pend.push_back('{in_rd_hi, alu_out[63:32]});
                    end
                end else begin
                    m_sq++;
                end
            end
            if (pend.size() > 0) begin
                e = pend.pop_front();
                m_en = 1; m_addr = e.addr; m_data = e.data;
            end else begin
                m_en = 0;
            end
            step();
            check("rnd_wb_en", wb_en, m_en);
            check("rnd_addr", wb_addr, m_addr);
            check("rnd_data", wb_data, m_data);
            check("rnd_flags", flags_q, m_flags);
            check("rnd_retired", retired, m_ret);
            check("rnd_squashed", squashed, m_sq);
        end

        // ---- squashed counter saturation with NV (S=1 must not touch flags)
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1, 4'hF, 1, 1, 0, 4'd5, 4'd0, 64'h55, 4'b1111);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_squashed_fffe", squashed, 16'hFFFE);
        repeat (6) @(posedge clk);
        #1;
        check("sat_squashed_ffff", squashed, 16'hFFFF);
        check("sat_retired", retired, 0);
        check("sat_flags", flags_q, 0);
        check("sat_wb_en", wb_en, 0);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
